// File: rtl/regfile_pkg.sv
// Shared widths and types for the general-purpose register file.
package regfile_pkg;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/register_file.sv
// NUM_REGS x DATA_W register file: one write port, two async read ports, r0 tap.
module register_file
  import regfile_pkg::reg_addr_t, regfile_pkg::reg_data_t;
#(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic      clk,
  input  logic      rstN,
  input  logic      writeEn,
  input  reg_addr_t dest,
  input  reg_data_t data,
  input  reg_addr_t rsAddr,
  input  reg_addr_t rdAddr,
  output reg_data_t rsOut,
  output reg_data_t rdOut,
  output reg_data_t r0
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_wr_ok;
  logic              w_wr;

  // Writes are held off for the first edge after reset release, so a release
  // landing on (or just before) an edge never lets that edge write.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_wr_ok <= 1'b0;
    else       r_wr_ok <= 1'b1;
  end

  assign w_wr = writeEn & r_wr_ok;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)     r_regs       <= '{default: '0};
    else if (w_wr) r_regs[dest] <= data;
  end

  assign rsOut = r_regs[rsAddr];
  assign rdOut = r_regs[rdAddr];
  assign r0    = r_regs[0];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rstN;
  logic      writeEn;
  reg_addr_t dest, rsAddr, rdAddr;
  reg_data_t data;
  reg_data_t rsOut, rdOut, r0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  register_file #(.DATA_W(8), .NUM_REGS(8)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .writeEn(writeEn),
    .dest   (dest),
    .data   (data),
    .rsAddr (rsAddr),
    .rdAddr (rdAddr),
    .rsOut  (rsOut),
    .rdOut  (rdOut),
    .r0     (r0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input reg_data_t got, input reg_data_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input reg_addr_t a, input reg_data_t d);
    @(negedge clk);
    dest = a; data = d; writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; writeEn = 1'b0; dest = '0; data = '0; rsAddr = '0; rdAddr = '0;
    #1;
    chk("rst_rs", rsOut, 8'h00);
    chk("rst_rd", rdOut, 8'h00);
    chk("rst_r0", r0,    8'h00);

    // Release mid-cycle, then one idle edge before the first write.
    @(negedge clk); rstN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) wr(reg_addr_t'(i), reg_data_t'(i));
    for (int i = 0; i < 8; i++) begin
      rsAddr = reg_addr_t'(i); #1;
      chk("fill_rs", rsOut, reg_data_t'(i));
    end
    for (int i = 0; i < 8; i++) begin
      rdAddr = reg_addr_t'(i); #1;
      chk("fill_rd", rdOut, reg_data_t'(i));
    end

    @(negedge clk);
    dest = 3'd3; data = 8'hAA; writeEn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rsAddr = 3'd3; #1;
    chk("wen0_hold", rsOut, 8'h03);

    wr(3'd0, 8'h5C);
    rsAddr = 3'd0; #1;
    chk("r0_track", r0, 8'h5C);
    chk("r0_rs", rsOut, 8'h5C);

    @(negedge clk);
    rsAddr = 3'd5; dest = 3'd5; data = 8'hF0; writeEn = 1'b1; #1;
    chk("nobyp_before", rsOut, 8'h05);
    @(posedge clk); #1;
    chk("nobyp_after", rsOut, 8'hF0);
    @(negedge clk); writeEn = 1'b0;

    wr(3'd7, 8'h77);
    rsAddr = 3'd7; rdAddr = 3'd7; #1;
    chk("dual_rs", rsOut, 8'h77);
    chk("dual_rd", rdOut, 8'h77);
    rdAddr = 3'd2; #1;
    chk("dual_rd2", rdOut, 8'h02);
    chk("dual_rs_keep", rsOut, 8'h77);

    // Asynchronous clear mid-cycle.
    @(posedge clk); #2 rstN = 1'b0; #1;
    chk("arst_r0", r0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rsAddr = reg_addr_t'(i); rdAddr = reg_addr_t'(7 - i); #1;
      chk("arst_rs", rsOut, 8'h00);
      chk("arst_rd", rdOut, 8'h00);
    end

    // Writes during reset are ignored.
    @(negedge clk);
    dest = 3'd1; data = 8'h11; writeEn = 1'b1; rsAddr = 3'd1;
    @(posedge clk); #1;
    chk("rst_wr_ignored", rsOut, 8'h00);

    // Release just ahead of an edge with writeEn held: that edge must not write.
    @(negedge clk); #4 rstN = 1'b1;
    @(posedge clk); #1;
    chk("release_edge_nowr", rsOut, 8'h00);
    @(posedge clk); #1;
    chk("release_next_wr", rsOut, 8'h11);
    @(negedge clk); writeEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
